// File: rtl/rom_fetch_sequencer.sv
// Program counter and one-entry fetch register for the 28-bit instruction ROM.
// Optional NOP timed-wait feature is enabled by defining FETCH_NOP_WAIT_EN.

`ifdef FETCH_NOP_WAIT_EN
`ifndef NOP
`define NOP 4'hF
`endif
`endif

module rom_fetch_sequencer #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 28
`ifdef FETCH_NOP_WAIT_EN
   ,
   parameter int WAIT_W  = 24
`endif
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oRomAddress,
   input  logic [INSTR_W-1:0] iRomInstruction,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [ADDR_W-1:0]  oPC,
   output logic               oInstrValid,
   input  logic               iStall,
   input  logic               iBranchTaken,
   input  logic [ADDR_W-1:0]  iBranchTarget
);

   typedef enum logic [0:0] {
      FETCH_ST = 1'b0,
      WAIT_ST  = 1'b1
   } state_t;

   state_t               state_r, state_s;
   logic [ADDR_W-1:0]    pc_r, pc_s;
   logic [INSTR_W-1:0]   instr_r, instr_s;
   logic [ADDR_W-1:0]    opc_r, opc_s;
   logic                 valid_r, valid_s;
`ifdef FETCH_NOP_WAIT_EN
   logic [WAIT_W-1:0]    cnt_r, cnt_s;
   logic                 nop_wait_s;
`endif

   assign oRomAddress  = pc_r;
   assign oInstruction = instr_r;
   assign oPC          = opc_r;
   assign oInstrValid  = valid_r;

`ifdef FETCH_NOP_WAIT_EN
   // A fetched NOP with nonzero immediate starts a timed wait.
   always_comb begin
      nop_wait_s = (iRomInstruction[27:24] == `NOP) && (iRomInstruction[23:0] != 24'd0);
   end
`endif

   // Next-state and next-register logic; branch beats stall beats fetch.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      opc_s   = opc_r;
      valid_s = valid_r;
`ifdef FETCH_NOP_WAIT_EN
      cnt_s   = cnt_r;
`endif
      case (state_r)
         FETCH_ST: begin
            if (iBranchTaken) begin
               pc_s    = iBranchTarget;
               valid_s = 1'b0;
            end else if (iStall) begin
               valid_s = valid_r;
            end else begin
               instr_s = iRomInstruction;
               opc_s   = pc_r;
               valid_s = 1'b1;
               pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef FETCH_NOP_WAIT_EN
               if (nop_wait_s) begin
                  cnt_s   = WAIT_W'(iRomInstruction[23:0] - 24'd1);
                  state_s = WAIT_ST;
               end else begin
                  state_s = FETCH_ST;
               end
`endif
            end
         end
`ifdef FETCH_NOP_WAIT_EN
         WAIT_ST: begin
            valid_s = 1'b0;
            if (iBranchTaken) begin
               pc_s    = iBranchTarget;
               cnt_s   = {WAIT_W{1'b0}};
               state_s = FETCH_ST;
            end else if (cnt_r == {WAIT_W{1'b0}}) begin
               state_s = FETCH_ST;
            end else if (!iStall) begin
               cnt_s = cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_s = cnt_r;
            end
         end
`endif
         default: begin
            state_s = FETCH_ST;
            valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= FETCH_ST;
         pc_r    <= {ADDR_W{1'b0}};
         instr_r <= {INSTR_W{1'b0}};
         opc_r   <= {ADDR_W{1'b0}};
         valid_r <= 1'b0;
`ifdef FETCH_NOP_WAIT_EN
         cnt_r   <= {WAIT_W{1'b0}};
`endif
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         opc_r   <= opc_s;
         valid_r <= valid_s;
`ifdef FETCH_NOP_WAIT_EN
         cnt_r   <= cnt_s;
`endif
      end
   end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Table-driven bench for rom_fetch_sequencer plus hand-written NOP-wait sequences.

`ifndef NOP
`define NOP 4'hF
`endif

module tb_rom_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] oRomAddress;
   logic [27:0] iRomInstruction;
   logic [27:0] oInstruction;
   logic [15:0] oPC;
   logic        oInstrValid;
   logic        iStall;
   logic        iBranchTaken;
   logic [15:0] iBranchTarget;

   int checks   = 0;
   int failures = 0;
   logic nop_mode = 1'b0;

   rom_fetch_sequencer dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .oRomAddress    (oRomAddress),
      .iRomInstruction(iRomInstruction),
      .oInstruction   (oInstruction),
      .oPC            (oPC),
      .oInstrValid    (oInstrValid),
      .iStall         (iStall),
      .iBranchTaken   (iBranchTaken),
      .iBranchTarget  (iBranchTarget)
   );

   always #5 Clock = ~Clock;

   function automatic logic [27:0] rom_word(input logic [15:0] a, input logic nm);
      logic [3:0] op;
      op = `NOP;
      if (nm && a == 16'h0000) return {op, 24'd3};
      return {12'h000, a};
   endfunction

   // ROM model: word equals address, or a NOP imm=3 at address 0 in nop_mode.
   always_comb iRomInstruction = rom_word(oRomAddress, nop_mode);

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [15:0] t,
                               input logic v, input logic [15:0] p, input logic [15:0] a);
      vec_t x;
      x.rst = r; x.stall = s; x.br = b; x.tgt = t;
      x.exp_valid = v; x.exp_pc = p; x.exp_addr = a;
      return x;
   endfunction

   // Runs reset then a NOP-at-0 program; returns bubble count before oPC=1 is valid.
   task automatic nop_run(input int stall_from, input int stall_len, output int bubbles);
      int cyc;
      nop_mode = 1'b1;
      Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0;
      tick(); tick();
      Reset = 1'b0;
      tick();
      check("nop_first_valid", {31'd0, oInstrValid}, 32'd1);
      check("nop_first_pc", {16'd0, oPC}, 32'd0);
      check("nop_first_instr", {4'd0, oInstruction}, {4'd0, rom_word(16'h0, 1'b1)});
      bubbles = 0;
      cyc = 0;
      while (!(oInstrValid && oPC == 16'h0001) && cyc < 20) begin
         iStall = (cyc >= stall_from && cyc < stall_from + stall_len);
         tick();
         if (!oInstrValid) bubbles++;
         cyc++;
      end
      iStall = 1'b0;
      check("nop_reached_pc1", {31'd0, (oInstrValid && oPC == 16'h0001)}, 32'd1);
      check("nop_pc1_instr", {4'd0, oInstruction}, 32'd1);
      nop_mode = 1'b0;
   endtask

   initial begin
      int b;
      int exp_b;
      Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0;

      // reset 3 cycles
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0));
      // stream 0..9
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 16'(i), 16'(i + 1)));
      // branch to 8 at oPC=9
      vecs.push_back(mk(0, 0, 1, 16'd8, 0, 16'd9, 16'd8));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd8, 16'd9));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd9, 16'd10));
      // go to 5, stall 4 cycles, release
      vecs.push_back(mk(0, 0, 1, 16'd5, 0, 16'd9, 16'd5));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd5, 16'd6));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 16'd5, 16'd6));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd6, 16'd7));
      // stall and branch together, target 14
      vecs.push_back(mk(0, 1, 1, 16'd14, 0, 16'd6, 16'd14));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd14, 16'd15));
      // wrap from FFFF
      vecs.push_back(mk(0, 0, 1, 16'hFFFF, 0, 16'd14, 16'hFFFF));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'hFFFF, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0001));
      // reset during stall
      vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 16'h0001));
      vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0001));
      // reset beats branch; branch to current PC refetches
      vecs.push_back(mk(1, 0, 1, 16'd7, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 16'h0001));
      vecs.push_back(mk(0, 0, 1, 16'd1, 0, 16'h0000, 16'h0001));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0001, 16'h0002));

      foreach (vecs[i]) begin
         Reset = vecs[i].rst;
         iStall = vecs[i].stall;
         iBranchTaken = vecs[i].br;
         iBranchTarget = vecs[i].tgt;
         tick();
         check($sformatf("v%0d_valid", i), {31'd0, oInstrValid}, {31'd0, vecs[i].exp_valid});
         check($sformatf("v%0d_pc", i), {16'd0, oPC}, {16'd0, vecs[i].exp_pc});
         check($sformatf("v%0d_instr", i), {4'd0, oInstruction}, {16'd0, vecs[i].exp_pc});
         check($sformatf("v%0d_addr", i), {16'd0, oRomAddress}, {16'd0, vecs[i].exp_addr});
      end
      iBranchTaken = 1'b0;

`ifdef FETCH_NOP_WAIT_EN
      exp_b = 3;
`else
      exp_b = 0;
`endif
      nop_run(100, 0, b);
      check("nop_bubbles", b, exp_b);
`ifdef FETCH_NOP_WAIT_EN
      exp_b = 5;
`else
      exp_b = 0;
`endif
      nop_run(1, 2, b);
      check("nop_stall_bubbles", b, exp_b);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
